// File: rtl/rf_pkg.sv
// Shared types and default sizing for the multiport register file.
`default_nettype none

package rf_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;

endpackage

`default_nettype wire

// File: rtl/rf_clear_fsm.sv
// Clear engine: walks a pointer over every entry after reset or on clr,
// requesting a zero write each cycle while busy.
`default_nettype none

module rf_clear_fsm
  import rf_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RF_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      RF_CLEAR: begin
        // Pointer wraps back to 0 naturally on the last entry.
        ptr_d = ptr_q + PTR_ONE;
        if (ptr_q == PTR_LAST) state_d = RF_IDLE;
      end
      default: begin
        if (clr) begin
          state_d = RF_CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  assign busy     = (state_q == RF_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = ptr_q;

endmodule

`default_nettype wire

// File: rtl/rf_multiport.sv
// Multiport register file with zero register, sequential clear engine and
// optional same-cycle write bypass (enabled by macro RF_BYPASS_EN).
`default_nettype none

module rf_multiport
  import rf_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = DEF_NUM_RD,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_ready,
  input  logic                     clr,
  output logic                     busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_to_zero;

  rf_clear_fsm #(
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign wr_ready   = !busy;
  assign wr_to_zero = (ZERO_REG != 0) && (wr_addr == '0);

  // Storage has no reset so it can map onto RAM; the clear engine zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_en && wr_ready && !wr_to_zero) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

    // Later assignments take priority: busy, then zero register, then bypass.
    always_comb begin
      data = mem_q[addr];
`ifdef RF_BYPASS_EN
      if (wr_en && wr_ready && (wr_addr == addr)) data = wr_data;
`endif
      if ((ZERO_REG != 0) && (addr == '0)) data = '0;
      if (busy) data = '0;
    end

    assign rd_data[gi*DATA_W +: DATA_W] = data;
  end

endmodule

`default_nettype wire

// File: doc/rf_multiport.md
# rf_multiport

Parametrised register file with DEPTH entries of DATA_W bits, NUM_RD combinational read ports and one synchronous write port. It is the register-file successor used by the datapath's decode/writeback stages. It adds the following:
- A hardwired zero register.
- Same-cycle write-to-read bypass.
- A sequential clear engine that zeroes storage one entry per cycle after reset or on request, so storage can map to RAM instead of resettable flops.

## Interface
- DATA_W, 32, entry width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at bits [i*DATA_W +: DATA_W]
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_ready  out  1  high when a write is accepted this cycle (= !busy)
- clr  in  1  synchronous clear request, single-cycle pulse
- busy  out  1  clear engine active

## Operation
- Clear FSM states:
  - CLEAR: clear pointer `ptr` counts 0..DEPTH-1 and writes 0 to `mem[ptr]` each cycle.
  - IDLE: normal operation.
- Asynchronous reset_n low forces state=CLEAR and ptr=0. The walk starts on the first rising edge after release.
- CLEAR -> IDLE on the edge that writes entry DEPTH-1. ptr wraps to 0.
- IDLE -> CLEAR on an edge with clr=1. clr during CLEAR is ignored; the walk does not restart.
- Write rules:
  - A write commits `mem[wr_addr] <= wr_data` on an edge when wr_en && wr_ready.
  - With ZERO_REG=1, wr_addr==0 is discarded.
  - Writes during CLEAR are dropped; the producer must hold them until wr_ready.
- Simultaneous clr and wr_en in IDLE: the write commits on that edge, and the following CLEAR walk zeroes it.
- Read rules:
  - Reads are combinational: `rd_data[i] = mem[rd_addr[i]]`.
  - Overrides, in priority order:
    1. busy=1 -> 0.
    2. ZERO_REG && rd_addr[i]==0 -> 0.
    3. Bypass hit (see Configuration) -> wr_data.
  - Multiple read ports may address the same entry; all receive identical data.
- Output values during and after reset:
  - busy=1, wr_ready=0, rd_data=0 while reset_n is low and throughout the ensuing walk.

## Timing
- Read latency 0 cycles (combinational from rd_addr and, with bypass, from wr_*).
- Write-to-read latency:
  - Without bypass, data is visible the cycle after the commit edge.
  - With bypass, data is visible in the same cycle as wr_en.
- Clear duration is exactly DEPTH cycles:
  - After reset: busy falls after the DEPTH-th rising edge following reset_n release.
  - After clr: busy rises on the edge that samples clr and stays high for DEPTH cycles.
- reset_n asserted mid-walk or mid-write aborts immediately. The walk restarts from ptr=0, and the in-flight write is not guaranteed.

## Configuration
- Macro RF_BYPASS_EN.
- Defined: a read port returns wr_data when all of the following hold:
  - wr_en is high and wr_ready is high.
  - wr_addr equals rd_addr[i].
  - The address is not the zero register when ZERO_REG=1.
- Undefined: no forwarding. A read of the entry being written returns the old value that cycle, and the bypass mux logic is absent.

## Structure
- Package rf_pkg holds:
  - The FSM state typedef (RF_IDLE, RF_CLEAR).
  - Default DATA_W/ADDR_W/NUM_RD constants.
- Sub-module rf_clear_fsm holds the state register and ptr counter. Its outputs are busy, clr_we and clr_addr.
- The top level holds the storage array, the write mux (clear engine vs. port) and the NUM_RD read/bypass muxes in a generate loop.

## Test plan
- Release reset_n, read all addresses on every port during the walk. Required: busy=1 for exactly 32 cycles (DEPTH=32), rd_data=0 throughout, and busy=0 on cycle 33.
- In IDLE, write 0xDEADBEEF to addr 7, then read port 0 at 7 and port 1 at 7 next cycle. Required: both ports return 0xDEADBEEF.
- Write 0x12345678 to addr 0 with ZERO_REG=1, then read addr 0. Required: 0x00000000.
- With RF_BYPASS_EN, drive wr_en with addr 3, data 0xA5A5A5A5 while rd_addr[0]=3. Required: rd_data[0]=0xA5A5A5A5 in the same cycle; without the macro, the previous value is returned.
- Fill addrs 1..31 with their index, pulse clr together with a write of 0xFF to addr 5. Required:
  - busy is high for 32 cycles and wr_ready is low during that time.
  - A write attempted mid-walk is dropped.
  - All entries read 0 afterwards.
- Assert reset_n low at walk cycle 10 for 1 cycle. Required: busy stays high, and the walk completes 32 cycles after the new release.
